// File: rtl/z_sched.sv
// z_sched: round-robin issue of per-channel Z-score triples to one shared unit with tag tracking and cooldown
module z_sched #(
    parameter int         N_CH     = 4,
    parameter int         UNIT_LAT = 1,
    parameter logic [7:0] COOLDOWN = 8'd16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [N_CH-1:0]    req_valid,
    output logic [N_CH-1:0]    req_ready,
    input  logic [N_CH*8-1:0]  req_mean,
    input  logic [N_CH*8-1:0]  req_data,
    input  logic [N_CH*16-1:0] req_sqr_mean,
    output logic               z_valid_pre,
    output logic [7:0]         z_mean,
    output logic [7:0]         z_data,
    output logic [15:0]        z_sqr_mean,
    input  logic               z_valid_in,
    input  logic               z_buy,
    input  logic               z_sell,
    output logic [N_CH-1:0]    rsp_valid,
    output logic               rsp_buy,
    output logic               rsp_sell,
    output logic               busy,
    output logic               err
);
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t          state;
    logic [IW-1:0]   last, gnt_idx, iss_idx, scan;
    logic            gnt, head_v, route;
    logic [IW-1:0]   head_i;
    logic [N_CH-1:0] infl, elig, xfer, clr;
    logic [7:0]      cd [N_CH];
    logic            tag_v [UNIT_LAT];
    logic [IW-1:0]   tag_i [UNIT_LAT];
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_CH; i++)
            elig[i] = req_valid[i] & ~infl[i] & (cd[i] == 8'd0) & (state == RUN);
    end
    // first eligible channel after the last winner, wrapping modulo N_CH
    always_comb begin
        gnt = 1'b0;
        gnt_idx = '0;
        scan = '0;
        for (int k = 1; k <= N_CH; k++) begin
            scan = IW'((int'(last) + k) % N_CH);
            if (!gnt && elig[scan]) begin
                gnt = 1'b1;
                gnt_idx = scan;
            end
        end
    end
    assign req_ready = gnt ? (N_CH'(1) << gnt_idx) : '0;
    assign xfer      = req_ready & req_valid;
    assign head_v    = tag_v[UNIT_LAT-1];
    assign head_i    = tag_i[UNIT_LAT-1];
    assign route     = head_v & z_valid_in;
    assign clr       = head_v ? (N_CH'(1) << head_i) : '0;
    assign busy      = (state != IDLE) || (infl != '0);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= IW'(N_CH - 1);
            infl        <= '0;
            iss_idx     <= '0;
            z_valid_pre <= 1'b0;
            z_mean      <= '0;
            z_data      <= '0;
            z_sqr_mean  <= '0;
            rsp_valid   <= '0;
            rsp_buy     <= 1'b0;
            rsp_sell    <= 1'b0;
            err         <= 1'b0;
            for (int i = 0; i < N_CH; i++) cd[i] <= 8'd0;
            for (int s = 0; s < UNIT_LAT; s++) begin
                tag_v[s] <= 1'b0;
                tag_i[s] <= '0;
            end
        end else begin
            state <= enable ? RUN :
                     (state == RUN) ? DRAIN :
                     (state == DRAIN && infl == '0) ? IDLE : state;
            z_valid_pre <= gnt;
            if (gnt) begin
                last       <= gnt_idx;
                iss_idx    <= gnt_idx;
                z_mean     <= req_mean[8*gnt_idx +: 8];
                z_data     <= req_data[8*gnt_idx +: 8];
                z_sqr_mean <= req_sqr_mean[16*gnt_idx +: 16];
            end
            // tag pipeline is fed from the issue register so its head lines up with z_valid_in
            tag_v[0] <= z_valid_pre;
            tag_i[0] <= iss_idx;
            for (int s = 1; s < UNIT_LAT; s++) begin
                tag_v[s] <= tag_v[s-1];
                tag_i[s] <= tag_i[s-1];
            end
            infl      <= (infl | xfer) & ~clr;
            rsp_valid <= route ? (N_CH'(1) << head_i) : '0;
            if (route) begin
                rsp_buy  <= z_buy;
                rsp_sell <= z_sell;
            end
            err <= err | (head_v ^ z_valid_in);
            for (int i = 0; i < N_CH; i++)
                cd[i] <= (route && head_i == IW'(i) && (z_buy || z_sell)) ? COOLDOWN :
                         (cd[i] != 8'd0) ? cd[i] - 8'd1 : 8'd0;
        end
    end
endmodule

// File: tb/tb_z_sched.sv
// tb_z_sched: randomized scoreboard bench for z_sched with a queue-based reference model
module tb_z_sched;
    localparam int         N  = 4;
    localparam int         L  = 1;
    localparam logic [7:0] CD = 8'd16;

    logic            clk = 1'b0;
    logic            rst_n, enable;
    logic [N-1:0]    req_valid, req_ready, rsp_valid;
    logic [N*8-1:0]  req_mean, req_data;
    logic [N*16-1:0] req_sqr_mean;
    logic            z_valid_pre, z_valid_in, z_buy, z_sell;
    logic [7:0]      z_mean, z_data;
    logic [15:0]     z_sqr_mean;
    logic            rsp_buy, rsp_sell, busy, err;

    z_sched #(.N_CH(N), .UNIT_LAT(L), .COOLDOWN(CD)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mean(req_mean), .req_data(req_data), .req_sqr_mean(req_sqr_mean),
        .z_valid_pre(z_valid_pre), .z_mean(z_mean), .z_data(z_data), .z_sqr_mean(z_sqr_mean),
        .z_valid_in(z_valid_in), .z_buy(z_buy), .z_sell(z_sell),
        .rsp_valid(rsp_valid), .rsp_buy(rsp_buy), .rsp_sell(rsp_sell),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    bit chk_on = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    // reference model: outstanding issues kept as (channel, edge at which the result is due)
    typedef struct { int idx; longint due; } tag_t;
    tag_t        q[$];
    int          m_state, m_last;
    bit          m_infl [N];
    int          m_cd [N];
    bit          m_zvp, m_buy, m_sell, m_err;
    logic [7:0]  m_mean, m_data;
    logic [15:0] m_sqr;
    logic [N-1:0] m_rsp;
    longint      cyc = 0;

    function automatic int pick();
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_last + k) % N;
            if (m_state == 1 && req_valid[j] && !m_infl[j] && m_cd[j] == 0) return j;
        end
        return -1;
    endfunction

    function automatic bit any_infl();
        for (int i = 0; i < N; i++) if (m_infl[i]) return 1;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int g, hi, nxt;
        bit hv, rt;
        if (!rst_n) begin
            q.delete();
            m_state = 0; m_last = N - 1;
            for (int i = 0; i < N; i++) begin m_infl[i] = 0; m_cd[i] = 0; end
            m_zvp = 0; m_buy = 0; m_sell = 0; m_err = 0;
            m_mean = 0; m_data = 0; m_sqr = 0; m_rsp = 0;
        end else begin
            g  = pick();
            hv = q.size() > 0 && q[0].due == cyc;
            hi = hv ? q[0].idx : 0;
            if (hv) void'(q.pop_front());
            rt = hv && z_valid_in;
            if (hv != z_valid_in) m_err = 1;
            m_rsp = '0;
            if (rt) begin m_rsp[hi] = 1; m_buy = z_buy; m_sell = z_sell; end
            if (enable) nxt = 1;
            else if (m_state == 1) nxt = 2;
            else if (m_state == 2 && !any_infl()) nxt = 0;
            else nxt = m_state;
            for (int i = 0; i < N; i++)
                if (rt && hi == i && (z_buy || z_sell)) m_cd[i] = CD;
                else if (m_cd[i] > 0) m_cd[i]--;
            if (hv) m_infl[hi] = 0;
            m_zvp = g >= 0;
            if (g >= 0) begin
                m_infl[g] = 1; m_last = g;
                m_mean = req_mean[8*g +: 8];
                m_data = req_data[8*g +: 8];
                m_sqr  = req_sqr_mean[16*g +: 16];
                q.push_back('{g, cyc + 1 + L});
            end
            m_state = nxt;
            cyc++;
        end
    end

    always @(negedge clk) begin
        int g;
        logic [N-1:0] er;
        if (chk_on) begin
            g = pick();
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            chk("req_ready", req_ready, er);
            chk("z_valid_pre", z_valid_pre, m_zvp);
            chk("z_mean", z_mean, m_mean);
            chk("z_data", z_data, m_data);
            chk("z_sqr_mean", z_sqr_mean, m_sqr);
            chk("rsp_valid", rsp_valid, m_rsp);
            if (m_rsp != 0) begin
                chk("rsp_buy", rsp_buy, m_buy);
                chk("rsp_sell", rsp_sell, m_sell);
            end
            chk("busy", busy, m_state != 0 || any_infl());
            chk("err", err, m_err);
        end
    end

    // shared unit stand-in: echoes z_valid_pre after L cycles; mode 0 hold, 1 random, 2 sell
    int   u_mode = 0;
    bit   u_inject = 0, u_drop = 0;
    logic dl [L] = '{default: 1'b0};
    always @(negedge clk) begin
        logic zv;
        #2;
        zv = dl[L-1];
        for (int s = L - 1; s > 0; s--) dl[s] = dl[s-1];
        dl[0] = z_valid_pre;
        z_valid_in = u_inject | (zv & ~u_drop);
        z_buy  = (u_mode == 1) ? 1'($urandom) : 1'b0;
        z_sell = (u_mode == 2) ? 1'b1 : (u_mode == 1) ? 1'($urandom) : 1'b0;
    end

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v == (N'(1) << i)) return i;
        return -1;
    endfunction

    initial begin
        int w, j, prev, ng, nbad, np;
        logic [N-1:0] seen;
        rst_n = 1; enable = 0; req_valid = 0;
        req_mean = 0; req_data = 0; req_sqr_mean = 0;
        z_valid_in = 0; z_buy = 0; z_sell = 0;
        #1 rst_n = 0;
        tick(2);
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_zvp", z_valid_pre, 0);
        chk_on = 1; rst_n = 1; enable = 1;
        tick(2);

        // single request on channel 0
        req_mean[7:0] = 8'd100; req_data[7:0] = 8'd120; req_sqr_mean[15:0] = 16'd10100;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("single_zvp", z_valid_pre, 1);
        chk("single_mean", z_mean, 100);
        chk("single_data", z_data, 120);
        chk("single_sqr", z_sqr_mean, 10100);
        #1 req_valid = 0;
        @(negedge clk);
        @(negedge clk);
        chk("single_rsp", rsp_valid, 4'b0001);
        #1;

        // fairness with hold results
        req_valid = 4'hf; prev = -1; ng = 0; nbad = 0; seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            j = idx_of(req_ready);
            if (j >= 0) begin
                ng++; seen[j] = 1'b1;
                if (prev >= 0 && j != (prev + 1) % N) nbad++;
                prev = j;
            end
        end
        chk("fair_grants", ng, 8);
        chk("fair_order", nbad, 0);
        chk("fair_seen", seen, 4'hf);
        #1 tick(30);

        // cooldown after a sell, then a hold result does not block
        req_valid = 0; tick(6);
        u_mode = 2; req_valid = 4'b0100;
        for (w = 0; w < 20; w++) begin @(negedge clk); if (rsp_valid[2]) break; end
        chk("cd_rsp_seen", w < 20, 1);
        #1 u_mode = 0;
        for (w = 1; w <= 40; w++) begin @(negedge clk); if (req_ready[2]) break; end
        chk("cd_gap", w, 16);
        for (w = 0; w < 20; w++) begin @(negedge clk); if (rsp_valid[2]) break; end
        chk("hold_ready", req_ready, 4'b0100);
        #1;

        // randomized traffic
        u_mode = 1;
        for (int c = 0; c < 800; c++) begin
            req_valid    = N'($urandom);
            req_mean     = $urandom;
            req_data     = $urandom;
            req_sqr_mean = {$urandom, $urandom};
            enable       = ($urandom % 16) != 0;
            u_drop       = ($urandom % 64) == 0;
            u_inject     = ($urandom % 97) == 0;
            tick(1);
        end
        u_drop = 0; u_inject = 0; u_mode = 0; enable = 1; req_valid = 0;
        tick(25);

        // drain with two tags in flight
        req_valid = 4'b0011;
        @(negedge clk); chk("drain_iss1", z_valid_pre, 1);
        @(negedge clk); chk("drain_iss2", z_valid_pre, 1);
        #1 enable = 0;
        np = 0; nbad = 0;
        for (w = 0; w < 20; w++) begin
            @(negedge clk);
            if (req_ready != 0) nbad++;
            if (rsp_valid != 0) np++;
            if (np == 2) begin
                chk("drain_busy_last", busy, 1);
                @(negedge clk);
                chk("drain_idle", busy, 0);
                break;
            end
        end
        chk("drain_pulses", np, 2);
        chk("drain_no_ready", nbad, 0);
        #1 req_valid = 0;

        // unmatched result sets a sticky error
        rst_n = 0; tick(2); rst_n = 1; enable = 1; tick(3);
        chk("mm_pre_err", err, 0);
        u_inject = 1; tick(1); u_inject = 0;
        @(negedge clk);
        chk("mm_err", err, 1);
        chk("mm_rsp", rsp_valid, 0);
        tick(5);
        chk("mm_sticky", err, 1);
        rst_n = 0;
        #1 chk("mm_rst_err", err, 0);

        // asynchronous reset while an issue is on the z_* port
        tick(2); rst_n = 1; enable = 1;
        req_mean = 32'h5a5a5a5a; req_data = 32'ha5a5a5a5; req_sqr_mean = {4{16'h1234}};
        tick(2);
        req_valid = 4'b0010;
        for (w = 0; w < 10; w++) begin @(negedge clk); if (z_valid_pre) break; end
        chk("ar_issue_seen", w < 10, 1);
        #3 rst_n = 0;
        #1;
        chk("ar_zvp", z_valid_pre, 0);
        chk("ar_mean", z_mean, 0);
        chk("ar_sqr", z_sqr_mean, 0);
        chk("ar_busy", busy, 0);
        chk("ar_ready", req_ready, 0);
        tick(2);
        rst_n = 1; req_valid = 4'hf;
        @(negedge clk);
        chk("ar_first_grant", req_ready, 4'b0001);
        #1 tick(20);
        chk_on = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
